// File: rtl/uart_tx_tick_pkg.sv
// Shared definitions for the tick-driven UART: FSM state encoding, parity modes
// and the parity helper (kept here so the future receiver can reuse them).
package uart_tx_tick_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SYNC   = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Word is zero-extended to 8 bits, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [7:0] word, input int mode);
    logic p;
    p = ^word;
    if (mode == PARITY_ODD) begin
      p = ~p;
    end else begin
      p = p;
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_tick.sv
// Byte-oriented UART transmitter; every bit cell lasts one period of the external
// bit-rate tick, so the baud rate is set entirely by the upstream divider.
module uart_tx_tick
  import uart_tx_tick_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 CLK50MHZ,
  input  logic                 RST_N,
  input  logic                 tick,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 done
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS);
  localparam logic [1:0]    LAST_STOP = 2'(STOP_BITS);

  logic [2:0]           state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [CW-1:0]        bitcnt_q, bitcnt_d;
  logic [1:0]           stopcnt_q, stopcnt_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 ready_q, ready_d;
  logic [7:0]           data_ext_s;

  // Zero-extend the payload so the parity helper sees a fixed width.
  always_comb begin
    data_ext_s = 8'h00;
    data_ext_s[DATA_BITS-1:0] = data;
  end

  // Next-state logic: everything past IDLE advances only on tick.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    stopcnt_d = stopcnt_q;
    par_d     = par_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (valid) begin
          shreg_d = data;
          par_d   = parity_bit(data_ext_s, PARITY);
          state_d = ST_SYNC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SYNC: begin
        // The start edge waits for a fresh tick so it is tick-aligned.
        if (tick) begin
          tx_d    = 1'b0;
          state_d = ST_START;
        end else begin
          state_d = ST_SYNC;
        end
      end
      ST_START: begin
        if (tick) begin
          tx_d     = shreg_q[0];
          shreg_d  = {1'b0, shreg_q[DATA_BITS-1:1]};
          bitcnt_d = CW'(1);
          state_d  = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bitcnt_q == LAST_BIT) begin
            if (PARITY != PARITY_NONE) begin
              tx_d    = par_q;
              state_d = ST_PARITY;
            end else begin
              tx_d      = 1'b1;
              stopcnt_d = 2'd1;
              state_d   = ST_STOP;
            end
          end else begin
            tx_d     = shreg_q[0];
            shreg_d  = {1'b0, shreg_q[DATA_BITS-1:1]};
            bitcnt_d = bitcnt_q + CW'(1);
            state_d  = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (tick) begin
          tx_d      = 1'b1;
          stopcnt_d = 2'd1;
          state_d   = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stopcnt_q == LAST_STOP) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stopcnt_d = stopcnt_q + 2'd1;
            state_d   = ST_STOP;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset abandons any frame with the line idle-high.
  always_ff @(posedge CLK50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      stopcnt_q <= 2'd0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      stopcnt_q <= stopcnt_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign tx    = tx_q;
  assign done  = done_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_uart_tx_tick.sv
// Directed bench for uart_tx_tick: three instances (8N1, 8E1, 8O2) share the tick
// and data; per-instance monitors decode frames and check them against queued words.
module tb_uart_tx_tick;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [7:0] data;
  logic [2:0] valid_s;
  logic [2:0] ready_s;
  logic [2:0] tx_s;
  logic [2:0] done_s;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int epoch = 0;
  int stall_events = 0;
  bit tick_run = 1'b0;
  int tdiv = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  uart_tx_tick #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n1 (
    .CLK50MHZ(clk), .RST_N(rst_n), .tick(tick), .data(data), .valid(valid_s[0]),
    .ready(ready_s[0]), .tx(tx_s[0]), .done(done_s[0]));
  uart_tx_tick #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_e1 (
    .CLK50MHZ(clk), .RST_N(rst_n), .tick(tick), .data(data), .valid(valid_s[1]),
    .ready(ready_s[1]), .tx(tx_s[1]), .done(done_s[1]));
  uart_tx_tick #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_o2 (
    .CLK50MHZ(clk), .RST_N(rst_n), .tick(tick), .data(data), .valid(valid_s[2]),
    .ready(ready_s[2]), .tx(tx_s[2]), .done(done_s[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Tick every 4 clocks, changed on the falling edge so it is stable at the rising edge.
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_run) begin
        tdiv = (tdiv == 3) ? 0 : tdiv + 1;
        tick = (tdiv == 0);
      end else begin
        tick = 1'b0;
      end
    end
  end

  function automatic int par_mode(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 2);
  endfunction

  function automatic int stop_n(input int k);
    return (k == 2) ? 2 : 1;
  endfunction

  function automatic logic exp_par(input logic [7:0] d, input int mode);
    return (^d) ^ (mode == 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic fail_now(input string tag);
    n_cmp++;
    n_bad++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic push_all(input logic [7:0] d);
    q0.push_back(d);
    q1.push_back(d);
    q2.push_back(d);
  endtask

  task automatic pop_exp(input int k, output logic [7:0] d, output bit ok);
    ok = 1'b1;
    d = 8'h00;
    case (k)
      0: if (q0.size() > 0) d = q0.pop_front(); else ok = 1'b0;
      1: if (q1.size() > 0) d = q1.pop_front(); else ok = 1'b0;
      default: if (q2.size() > 0) d = q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  // Advance to the next tick edge (sampled 1 time unit after it); aborts on reset.
  task automatic next_tick(input int k, input int ep, inout bit ab);
    int n;
    bit got;
    got = ab;
    n = 0;
    while (!got) begin
      @(posedge clk); #1;
      n++;
      if (epoch != ep) begin
        ab = 1'b1;
        got = 1'b1;
      end else if (tick) begin
        got = 1'b1;
      end else begin
        chk($sformatf("done_low_mid_frame_%0d", k), 32'(done_s[k]), 32'd0);
        if (n >= 400) begin
          fail_now($sformatf("tick_wait_%0d", k));
          ab = 1'b1;
          got = 1'b1;
        end
      end
    end
  endtask

  // Per-instance frame decoder and line checker.
  for (genvar k = 0; k < 3; k++) begin : g_mon
    initial begin
      logic [7:0] got_d;
      logic [7:0] exp_d;
      logic       pbit;
      int         t0, ep, st0, fl;
      bit         ab, ok;
      forever begin
        @(posedge clk); #1;
        if (rst_n && tick && tx_s[k] === 1'b0) begin
          t0 = cyc; ep = epoch; st0 = stall_events; ab = 1'b0; pbit = 1'b0; got_d = 8'h00;
          for (int i = 0; i < 8; i++) begin
            next_tick(k, ep, ab);
            got_d[i] = tx_s[k];
          end
          if (par_mode(k) != 0) begin
            next_tick(k, ep, ab);
            pbit = tx_s[k];
          end
          for (int s = 0; s < stop_n(k); s++) begin
            next_tick(k, ep, ab);
            if (!ab) chk($sformatf("stop_cell_%0d_%0d", k, s), 32'(tx_s[k]), 32'd1);
          end
          next_tick(k, ep, ab);
          if (!ab) begin
            chk($sformatf("done_pulse_%0d", k), 32'(done_s[k]), 32'd1);
            pop_exp(k, exp_d, ok);
            if (!ok) begin
              fail_now($sformatf("unexpected_frame_%0d", k));
            end else begin
              chk($sformatf("frame_data_%0d", k), 32'(got_d), 32'(exp_d));
              if (par_mode(k) != 0)
                chk($sformatf("parity_cell_%0d", k), 32'(pbit), 32'(exp_par(exp_d, par_mode(k))));
            end
            fl = 9 + ((par_mode(k) != 0) ? 1 : 0) + stop_n(k);
            if (stall_events == st0)
              chk($sformatf("frame_cycles_%0d", k), 32'(cyc - t0), 32'(fl * 4));
            @(posedge clk); #1;
            chk($sformatf("done_one_cycle_%0d", k), 32'(done_s[k]), 32'd0);
          end
        end
      end
    end

    // tx may only change on edges where tick was high (reset excepted).
    initial begin
      logic prev;
      bit   prev_rst;
      prev = 1'b1;
      prev_rst = 1'b0;
      forever begin
        @(posedge clk); #1;
        if (rst_n && prev_rst && !tick)
          chk($sformatf("tx_hold_%0d", k), 32'(tx_s[k]), 32'(prev));
        prev = tx_s[k];
        prev_rst = rst_n;
      end
    end
  end

  task automatic wait_idle(input string tag);
    int n;
    bit idle;
    n = 0;
    idle = 1'b0;
    while (!idle && n < 2000) begin
      @(posedge clk); #1;
      n++;
      idle = (q0.size() == 0) && (q1.size() == 0) && (q2.size() == 0) && (ready_s == 3'b111);
    end
    if (!idle) fail_now(tag);
    repeat (3) @(posedge clk);
  endtask

  task automatic send_pulse(input logic [7:0] d);
    @(negedge clk);
    data = d;
    valid_s = 3'b111;
    push_all(d);
    @(posedge clk); #1;
    chk("ready_drop", 32'(ready_s), 32'd0);
    @(negedge clk);
    valid_s = 3'b000;
  endtask

  task automatic b2b(input int k);
    int n, cd, rc, ts;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (done_s[k]) seen = 1'b1;
    end
    if (!seen) begin
      fail_now($sformatf("b2b_done_%0d", k));
    end else begin
      cd = cyc;
      rc = ready_s[k] ? 1 : 0;
      ts = -1;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        if (ready_s[k]) rc++;
        if (ts < 0 && tx_s[k] === 1'b0) ts = cyc;
      end
      chk($sformatf("b2b_ready_once_%0d", k), 32'(rc), 32'd1);
      chk($sformatf("b2b_start_gap_%0d", k), 32'(ts - cd), 32'd4);
    end
    @(negedge clk);
    valid_s[k] = 1'b0;
  endtask

  task automatic wait_start0(input string tag);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk); #1;
      n++;
      seen = tick && (tx_s[0] === 1'b0);
    end
    if (!seen) fail_now(tag);
  endtask

  task automatic wait_ticks(input int cnt);
    int seen_t, n;
    seen_t = 0;
    n = 0;
    while (seen_t < cnt && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (tick) seen_t++;
    end
  endtask

  initial begin
    logic [2:0] txv;
    int n;
    rst_n = 1'b0;
    data = 8'h00;
    valid_s = 3'b000;
    tick_run = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", 32'(tx_s), 32'h7);
    chk("reset_ready", 32'(ready_s), 32'h7);
    chk("reset_done", 32'(done_s), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic frame on all three formats.
    send_pulse(8'hA5);
    wait_idle("idle_after_a5");

    // Acceptance on the same edge as a tick: start waits for the next tick.
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!tick && n < 20);
    repeat (4) @(negedge clk);
    data = 8'h96;
    valid_s = 3'b111;
    push_all(8'h96);
    @(posedge clk); #1;
    chk("sync_ready_low", 32'(ready_s), 32'd0);
    chk("sync_tx_high_0", 32'(tx_s), 32'h7);
    @(negedge clk);
    valid_s = 3'b000;
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("sync_tx_high_%0d", i), 32'(tx_s), 32'h7);
    end
    @(posedge clk); #1;
    chk("start_on_next_tick", 32'(tx_s), 32'h0);
    wait_idle("idle_after_96");

    // Tick stalled for 100 clocks mid-frame.
    send_pulse(8'hC3);
    wait_start0("stall_start");
    wait_ticks(3);
    @(negedge clk);
    tick_run = 1'b0;
    stall_events++;
    txv = tx_s;
    repeat (100) @(posedge clk);
    #1;
    chk("stall_tx_held", 32'(tx_s), 32'(txv));
    @(negedge clk);
    tick_run = 1'b1;
    wait_idle("idle_after_stall");

    // Valid held across two words.
    @(negedge clk);
    data = 8'h00;
    valid_s = 3'b111;
    push_all(8'h00);
    push_all(8'h00);
    fork
      b2b(0);
      b2b(1);
      b2b(2);
    join
    wait_idle("idle_after_b2b");

    // Asynchronous reset during data bit 3, then a clean frame.
    send_pulse(8'h5A);
    wait_start0("reset_start");
    wait_ticks(4);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    epoch++;
    #1;
    chk("async_reset_tx", 32'(tx_s), 32'h7);
    chk("async_reset_ready", 32'(ready_s), 32'h7);
    chk("async_reset_done", 32'(done_s), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("reset_no_done_%0d", i), 32'(done_s), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    q0.delete();
    q1.delete();
    q2.delete();
    repeat (2) @(posedge clk);
    send_pulse(8'h3C);
    wait_idle("idle_after_3c");

    chk("queues_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
